// File: rtl/aes_pkg.sv
// Shared definitions for the iterative AES inverse cipher.
//   - aes_state_e     : controller FSM encoding (IDLE, ROUND, FINAL, DONE)
//   - AES_BLOCK_W     : block / state / round-key width in bits
//   - NR_AES*         : round counts for the three AES key sizes
//   - gf_mul, gf_inv  : GF(2^8) arithmetic over x^8+x^4+x^3+x+1
//   - inv_shift_rows, inv_sub_bytes, inv_mix_columns : combinational round steps
// Byte layout everywhere: byte 0 in [127:120], column-major, so byte (row r,
// column c) is byte index 4*c+r.
package aes_pkg;

    localparam int AES_BLOCK_W = 128;
    localparam int NR_AES128   = 10;
    localparam int NR_AES192   = 12;
    localparam int NR_AES256   = 14;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ROUND = 2'd1,
        FINAL = 2'd2,
        DONE  = 2'd3
    } aes_state_e;

    // MSB position of byte (row r, column c) inside a block.
    function automatic int byte_msb(input int c, input int r);
        return AES_BLOCK_W - 1 - 8 * (4 * c + r);
    endfunction

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] aa;
        p  = 8'h00;
        aa = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ aa;
            aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    // Multiplicative inverse as x^254 (= x^2 * x^4 * ... * x^128); 0 maps to 0.
    function automatic logic [7:0] gf_inv(input logic [7:0] x);
        logic [7:0] p;
        logic [7:0] r;
        p = x;
        r = 8'h01;
        for (int i = 0; i < 7; i++) begin
            p = gf_mul(p, p);
            r = gf_mul(r, p);
        end
        return r;
    endfunction

    // Inverse S-box: undo the affine map (rotl 1, 3, 6 xor 0x05), then invert.
    function automatic logic [7:0] inv_sbox(input logic [7:0] s);
        logic [7:0] b;
        b = {s[6:0], s[7]} ^ {s[4:0], s[7:5]} ^ {s[1:0], s[7:2]} ^ 8'h05;
        return gf_inv(b);
    endfunction

    // Row r rotates right by r columns.
    function automatic logic [AES_BLOCK_W-1:0] inv_shift_rows(input logic [AES_BLOCK_W-1:0] s);
        logic [AES_BLOCK_W-1:0] o;
        o = '0;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                o[byte_msb(c, r) -: 8] = s[byte_msb((c + 4 - r) % 4, r) -: 8];
            end
        end
        return o;
    endfunction

    function automatic logic [AES_BLOCK_W-1:0] inv_sub_bytes(input logic [AES_BLOCK_W-1:0] s);
        logic [AES_BLOCK_W-1:0] o;
        o = '0;
        for (int i = 0; i < AES_BLOCK_W / 8; i++) begin
            o[AES_BLOCK_W-1-8*i -: 8] = inv_sbox(s[AES_BLOCK_W-1-8*i -: 8]);
        end
        return o;
    endfunction

    function automatic logic [AES_BLOCK_W-1:0] inv_mix_columns(input logic [AES_BLOCK_W-1:0] s);
        logic [AES_BLOCK_W-1:0] o;
        logic [31:0]            col;
        o = '0;
        for (int c = 0; c < 4; c++) begin
            col = s[AES_BLOCK_W-1-32*c -: 32];
            for (int r = 0; r < 4; r++) begin
                o[byte_msb(c, r) -: 8] = gf_mul(col[31-8*r -: 8],             8'h0e)
                                       ^ gf_mul(col[31-8*((r + 1) % 4) -: 8], 8'h0b)
                                       ^ gf_mul(col[31-8*((r + 2) % 4) -: 8], 8'h0d)
                                       ^ gf_mul(col[31-8*((r + 3) % 4) -: 8], 8'h09);
            end
        end
        return o;
    endfunction

endpackage

// File: rtl/aes_inv_round.sv
// One AES inverse round, purely combinational.
//   state  : current cipher state
//   rk     : round key applied in this round
//   last   : 1 for the final round (no InvMixColumns)
//   result : InvMixColumns(InvSubBytes(InvShiftRows(state)) ^ rk), or without
//            the InvMixColumns step when last is set
module aes_inv_round
    import aes_pkg::*;
(
    input  logic [AES_BLOCK_W-1:0] state,
    input  logic [AES_BLOCK_W-1:0] rk,
    input  logic                   last,
    output logic [AES_BLOCK_W-1:0] result
);

    logic [AES_BLOCK_W-1:0] keyed;

    assign keyed  = inv_sub_bytes(inv_shift_rows(state)) ^ rk;
    assign result = last ? keyed : inv_mix_columns(keyed);

endmodule

// File: rtl/aes_inv_cipher_ctrl.sv
// Iterative AES decryption engine: one inverse round per clock.
// Ports:
//   clk, rst_n            clock (rising edge), async active-low reset
//   in_valid/in_ready     ciphertext handshake, in_block = ciphertext
//   rk_addr/rk_data       round-key store read, same-cycle data
//   out_valid/out_ready   plaintext handshake, out_block = plaintext
//   busy                  high whenever the FSM is not IDLE
// Handshake: a transfer occurs on a rising edge where valid and ready are both
// high; the source keeps valid and data stable until then. in_ready is high
// only in IDLE, out_valid only in DONE, so blocks never overlap.
// Sequence per block: IDLE (whitening with key NR), ROUND for keys NR-1..1,
// FINAL with key 0, DONE until the plaintext is taken.
// fsm_q is the FSM state register, visible to bound checkers by name.
module aes_inv_cipher_ctrl
    import aes_pkg::*;
#(
    parameter int NR    = NR_AES128,
    parameter int RKA_W = 4          // 2**RKA_W must exceed NR
)(
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [AES_BLOCK_W-1:0] in_block,
    output logic [RKA_W-1:0]       rk_addr,
    input  logic [AES_BLOCK_W-1:0] rk_data,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [AES_BLOCK_W-1:0] out_block,
    output logic                   busy
);

    localparam logic [RKA_W-1:0] RK_LAST = RKA_W'(NR);
    localparam logic [RKA_W-1:0] RK_ONE  = RKA_W'(1);

    aes_state_e             fsm_q, fsm_d;
    logic [RKA_W-1:0]       rnd_q, rnd_d;
    logic [AES_BLOCK_W-1:0] state_q, state_d;
    logic [AES_BLOCK_W-1:0] round_out;
    logic                   last;

    aes_inv_round u_round (
        .state  (state_q),
        .rk     (rk_data),
        .last   (last),
        .result (round_out)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fsm_q   <= IDLE;
            rnd_q   <= '0;
            state_q <= '0;
        end else begin
            fsm_q   <= fsm_d;
            rnd_q   <= rnd_d;
            state_q <= state_d;
        end
    end

    // rk_addr depends only on fsm_q and rnd_q; it stays within 0..NR.
    always_comb begin
        fsm_d     = fsm_q;
        rnd_d     = rnd_q;
        state_d   = state_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        rk_addr   = RK_LAST;
        last      = 1'b0;
        case (fsm_q)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    state_d = in_block ^ rk_data;
                    rnd_d   = RK_LAST - RK_ONE;
                    fsm_d   = ROUND;
                end
            end
            ROUND: begin
                rk_addr = rnd_q;
                state_d = round_out;
                // Leave at rnd==1 so rnd never wraps; key 0 belongs to FINAL.
                if (rnd_q == RK_ONE) fsm_d = FINAL;
                else                 rnd_d = rnd_q - RK_ONE;
            end
            FINAL: begin
                rk_addr = '0;
                last    = 1'b1;
                state_d = round_out;
                fsm_d   = DONE;
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) fsm_d = IDLE;
            end
            default: fsm_d = IDLE;
        endcase
    end

    assign out_block = state_q;
    assign busy      = (fsm_q != IDLE);

endmodule

// File: tb/tb_aes_inv_cipher_ctrl.sv
module tb_aes_inv_cipher_ctrl;

  localparam logic [127:0] KEY_128 = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [255:0] KEY_256 = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
  localparam logic [127:0] PT_FIPS = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] CT_C1   = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] CT_C3   = 128'h8ea2b7ca516745bfeafc49904b496089;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   cyc = 0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // ---------------- DUT NR=10 ----------------
  logic         in_valid, in_ready, out_valid, out_ready, busy;
  logic [127:0] in_block, rk_data, out_block;
  logic [3:0]   rk_addr;
  logic [127:0] ks10 [0:15];
  assign rk_data = ks10[rk_addr];

  aes_inv_cipher_ctrl #(.NR(10), .RKA_W(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_block(in_block),
    .rk_addr(rk_addr), .rk_data(rk_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_block(out_block),
    .busy(busy)
  );

  // ---------------- DUT NR=14 ----------------
  logic         in_valid_14, in_ready_14, out_valid_14, out_ready_14, busy_14;
  logic [127:0] in_block_14, rk_data_14, out_block_14;
  logic [3:0]   rk_addr_14;
  logic [127:0] ks14 [0:15];
  assign rk_data_14 = ks14[rk_addr_14];

  aes_inv_cipher_ctrl #(.NR(14), .RKA_W(4)) dut_14 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid_14), .in_ready(in_ready_14), .in_block(in_block_14),
    .rk_addr(rk_addr_14), .rk_data(rk_data_14),
    .out_valid(out_valid_14), .out_ready(out_ready_14), .out_block(out_block_14),
    .busy(busy_14)
  );

  // ---------------- checking ----------------
  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // ---------------- reference model (forward cipher) ----------------
  logic [7:0] sbox [0:255];

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] aa;
    p  = 8'h00;
    aa = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ aa;
      aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
    logic [15:0] d;
    d = {b, b} << n;
    return d[15:8];
  endfunction

  // Forward S-box from a brute-force inverse search plus the affine map.
  task automatic build_sbox();
    logic [7:0] inv;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      for (int y = 1; y < 256; y++)
        if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      sbox[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
    end
  endtask

  // Key schedule; key is left-aligned in 256 bits, Nk = nr - 6.
  function automatic logic [127:0] round_key(input logic [255:0] key, input int nr, input int r);
    logic [31:0] w [0:59];
    logic [31:0] t;
    logic [7:0]  rc;
    int          nk;
    nk = nr - 6;
    rc = 8'h01;
    for (int i = 0; i < 60; i++) w[i] = 32'h0;
    for (int i = 0; i < nk; i++) w[i] = key[255-32*i -: 32];
    for (int i = nk; i < 4 * (nr + 1); i++) begin
      t = w[i-1];
      if (i % nk == 0) begin
        t  = {sbox[t[23:16]], sbox[t[15:8]], sbox[t[7:0]], sbox[t[31:24]]} ^ {rc, 24'h0};
        rc = gmul(rc, 8'h02);
      end else if (nk > 6 && i % nk == 4) begin
        t = {sbox[t[31:24]], sbox[t[23:16]], sbox[t[15:8]], sbox[t[7:0]]};
      end
      w[i] = w[i-nk] ^ t;
    end
    return {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endfunction

  function automatic logic [127:0] sub_shift(input logic [127:0] s);
    logic [127:0] o;
    o = '0;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        o[127-8*(4*c+r) -: 8] = sbox[s[127-8*(4*((c+r)%4)+r) -: 8]];
    return o;
  endfunction

  function automatic logic [127:0] mix_cols(input logic [127:0] s);
    logic [127:0] o;
    logic [7:0]   a0, a1, a2, a3;
    o = '0;
    for (int c = 0; c < 4; c++) begin
      {a0, a1, a2, a3} = s[127-32*c -: 32];
      o[127-32*c -: 32] = {gmul(a0, 8'h02) ^ gmul(a1, 8'h03) ^ a2 ^ a3,
                           a0 ^ gmul(a1, 8'h02) ^ gmul(a2, 8'h03) ^ a3,
                           a0 ^ a1 ^ gmul(a2, 8'h02) ^ gmul(a3, 8'h03),
                           gmul(a0, 8'h03) ^ a1 ^ a2 ^ gmul(a3, 8'h02)};
    end
    return o;
  endfunction

  function automatic logic [127:0] encrypt10(input logic [127:0] pt);
    logic [127:0] s;
    s = pt ^ ks10[0];
    for (int r = 1; r < 10; r++) s = mix_cols(sub_shift(s)) ^ ks10[r];
    return sub_shift(s) ^ ks10[10];
  endfunction

  // ---------------- scoreboard / monitor ----------------
  logic [127:0] exp_q [$];
  logic [3:0]   rk_hist [0:1023];
  logic         rk_over = 1'b0;

  always @(negedge clk) begin
    if (cyc < 1024) rk_hist[cyc] <= rk_addr;
    if (rst_n && (rk_addr > 4'd10 || rk_addr_14 > 4'd14)) rk_over <= 1'b1;
    if (rst_n && out_valid && out_ready) begin
      if (exp_q.size() == 0) check("sb_extra_output", 128'(out_valid), 128'd0);
      else                   check("sb_plaintext", out_block, exp_q.pop_front());
    end
  end

  // ---------------- driver tasks (enter and leave 1 time unit after posedge) ----------------
  task automatic send(input logic [127:0] ct, input logic [127:0] pt, output int acc);
    int budget;
    budget = 0;
    exp_q.push_back(pt);
    in_block = ct;
    in_valid = 1'b1;
    while (!in_ready && budget < 200) begin
      tick();
      budget++;
    end
    if (!in_ready) check("send_timeout", 128'(in_ready), 128'd1);
    acc = cyc;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic wait_out(input int acc, input int lat, input string tag);
    int budget;
    budget = 0;
    while (!out_valid && budget < 100) begin
      tick();
      budget++;
    end
    check(tag, 128'(cyc - acc), 128'(lat));
  endtask

  task automatic drain();
    int budget;
    budget = 0;
    while (exp_q.size() > 0 && budget < 100) begin
      tick();
      budget++;
    end
    check("drain_empty", 128'(exp_q.size()), 128'd0);
  endtask

  // ---------------- test sequence ----------------
  initial begin : main
    int           acc, acc2;
    logic [127:0] pt_a, pt_b;
    logic         seen;
    in_valid     = 1'b0;
    in_block     = '0;
    out_ready    = 1'b1;
    in_valid_14  = 1'b0;
    in_block_14  = '0;
    out_ready_14 = 1'b1;

    build_sbox();
    for (int r = 0; r < 16; r++) begin
      ks10[r] = (r <= 10) ? round_key({KEY_128, 128'h0}, 10, r) : 128'h0;
      ks14[r] = (r <= 14) ? round_key(KEY_256, 14, r) : 128'h0;
    end

    // Reset values while rst_n is held low.
    repeat (3) tick();
    check("rst_in_ready",  128'(in_ready),  128'd1);
    check("rst_out_valid", 128'(out_valid), 128'd0);
    check("rst_busy",      128'(busy),      128'd0);
    check("rst_out_block", out_block,       128'd0);
    check("rst_rk_addr",   128'(rk_addr),   128'd10);
    rst_n = 1'b1;
    tick();

    // FIPS-197 C.1 with latency and round-key address trace.
    send(CT_C1, PT_FIPS, acc);
    wait_out(acc, 11, "lat_c1");
    for (int i = 0; i <= 10; i++) check("rk_trace", 128'(rk_hist[acc+i]), 128'(10 - i));
    tick();
    check("idle_rk_addr", 128'(rk_addr), 128'd10);
    check("idle_flags", 128'({in_ready, out_valid, busy}), 128'(3'b100));

    // Backpressure: plaintext held while out_ready is low.
    repeat ($urandom_range(0, 3)) tick();
    out_ready = 1'b0;
    pt_a = {$urandom, $urandom, $urandom, $urandom};
    send(encrypt10(pt_a), pt_a, acc);
    wait_out(acc, 11, "lat_bp");
    repeat (20) begin
      tick();
      check("bp_block", out_block, pt_a);
      check("bp_flags", 128'({out_valid, in_ready, busy}), 128'(3'b101));
    end
    out_ready = 1'b1;
    tick();
    check("bp_release", 128'({out_valid, in_ready, busy}), 128'(3'b010));
    check("bp_popped", 128'(exp_q.size()), 128'd0);

    // Back-to-back: in_valid stays high across two blocks.
    pt_a = {$urandom, $urandom, $urandom, $urandom};
    pt_b = {$urandom, $urandom, $urandom, $urandom};
    send(encrypt10(pt_a), pt_a, acc);
    send(encrypt10(pt_b), pt_b, acc2);
    check("b2b_gap", 128'(acc2 - acc), 128'd12);
    drain();

    // Reset mid-block at rnd=5, then a clean block.
    send(CT_C1, PT_FIPS, acc);
    repeat (4) tick();
    check("pre_rst_rk_addr", 128'(rk_addr), 128'd5);
    rst_n = 1'b0;
    #1;
    check("mid_rst_flags",  128'({in_ready, out_valid, busy}), 128'(3'b100));
    check("mid_rst_block",  out_block, 128'd0);
    check("mid_rst_rk",     128'(rk_addr), 128'd10);
    exp_q.delete();
    tick();
    tick();
    rst_n = 1'b1;
    seen = 1'b0;
    repeat (15) begin
      tick();
      if (out_valid) seen = 1'b1;
    end
    check("rst_no_output", 128'(seen), 128'd0);
    send(CT_C1, PT_FIPS, acc);
    wait_out(acc, 11, "lat_after_rst");
    drain();

    // NR=14, FIPS-197 C.3.
    check("c3_in_ready", 128'(in_ready_14), 128'd1);
    in_block_14 = CT_C3;
    in_valid_14 = 1'b1;
    acc = cyc;
    tick();
    in_valid_14 = 1'b0;
    begin : wait_14
      int budget;
      budget = 0;
      while (!out_valid_14 && budget < 100) begin
        tick();
        budget++;
      end
    end
    check("lat_c3", 128'(cyc - acc), 128'd15);
    check("c3_plain", out_block_14, PT_FIPS);
    tick();
    check("c3_idle", 128'({in_ready_14, busy_14}), 128'(2'b10));

    check("rk_addr_range", 128'(rk_over), 128'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin : watchdog
    #300000;
    $display("FAIL watchdog: simulation did not finish (checks %0d, errors %0d)", n_checks, n_errors);
    $fatal(1);
  end

endmodule
